fft_out_fifo: RTL and testbench



---
 rtl/fft_out_fifo_pkg.sv | 32 +++
 rtl/fft_out_fifo_if.sv | 49 ++++
 rtl/fft_fifo_mem.sv | 37 +++
 rtl/fft_out_fifo.sv | 149 ++++++++++++++
 tb/tb_fft_out_fifo.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/fft_out_fifo_pkg.sv
// -----------------------------------------------------------------------------
// fft_out_fifo_pkg
// Shared FFT parameters and types used by the FFT output FIFO, its RAM and
// its interface:
//   FFT_SAMPLE_W   width of one real or imaginary sample component
//   FFT_WORD_W     width of one stored complex sample {real, imag}
//   FFT_FRAME_LEN  samples per FFT frame
//   FFT_FIFO_DEPTH default number of FIFO entries (two frames)
// -----------------------------------------------------------------------------
package fft_out_fifo_pkg;

  localparam int FFT_SAMPLE_W   = 16;
  localparam int FFT_WORD_W     = 2 * FFT_SAMPLE_W;
  localparam int FFT_FRAME_LEN  = 16;
  localparam int FFT_FIFO_DEPTH = 2 * FFT_FRAME_LEN;

  typedef logic [FFT_SAMPLE_W-1:0] sample_t;

  // Stored word layout: real part in the upper half, imaginary in the lower.
  typedef struct packed {
    sample_t re;
    sample_t im;
  } word_t;

  function automatic word_t pack_word(input sample_t re, input sample_t im);
    word_t w;
    w.re = re;
    w.im = im;
    return w;
  endfunction

endpackage

// File: rtl/fft_out_fifo_if.sv
// -----------------------------------------------------------------------------
// fft_out_fifo_if
// Bundles the upstream (FFT core) and downstream handshake/data signals of
// the FFT output FIFO.
//   master modport : the environment (drives in_push/in_real/in_imag and
//                    out_stall, observes everything else)
//   slave modport  : the FIFO itself
// Signals:
//   in_push, in_real, in_imag   one sample per cycle from the FFT core
//   in_stall_F                  fewer than one frame of free space left
//   out_push_F, out_real_F,
//   out_imag_F, out_last_F      registered downstream sample stream
//   out_stall                   downstream back-pressure
//   overflow_F                  sticky drop indicator
//   count_F                     current occupancy
// -----------------------------------------------------------------------------
interface fft_out_fifo_if
  import fft_out_fifo_pkg::*;
#(
  parameter int DEPTH = FFT_FIFO_DEPTH
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_push;
  sample_t       in_real;
  sample_t       in_imag;
  logic          in_stall_F;
  logic          out_push_F;
  sample_t       out_real_F;
  sample_t       out_imag_F;
  logic          out_last_F;
  logic          out_stall;
  logic          overflow_F;
  logic [CW-1:0] count_F;

  modport master (
    output in_push, in_real, in_imag, out_stall,
    input  in_stall_F, out_push_F, out_real_F, out_imag_F, out_last_F,
           overflow_F, count_F
  );

  modport slave (
    input  in_push, in_real, in_imag, out_stall,
    output in_stall_F, out_push_F, out_real_F, out_imag_F, out_last_F,
           overflow_F, count_F
  );

endinterface

// File: rtl/fft_fifo_mem.sv
// -----------------------------------------------------------------------------
// fft_fifo_mem
// DEPTH x 32-bit storage for the FFT output FIFO. One synchronous write port
// and one asynchronous (combinational) read port; contents are not reset.
// Ports:
//   clk    rising-edge clock for the write port
//   we     write enable
//   waddr  write address
//   wdata  word to store {real, imag}
//   raddr  read address
//   rdata  word at raddr, combinational
// -----------------------------------------------------------------------------
module fft_fifo_mem
  import fft_out_fifo_pkg::*;
#(
  parameter int DEPTH = FFT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  word_t                    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output word_t                    rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read is combinational so the pop can register the word in the same edge.
  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_out_fifo.sv
// -----------------------------------------------------------------------------
// fft_out_fifo
// Rate-decoupling FIFO between an FFT core (which never stalls) and a
// downstream consumer that may apply back-pressure. Samples leave in the
// order they arrived; out_last_F marks the final sample of every frame.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    fft_out_fifo_if.slave (see the interface file for signal roles)
// Behaviour summary:
//   - a push is accepted whenever the FIFO is not full, otherwise it is
//     dropped and overflow_F is set (sticky until reset);
//   - a pop happens whenever the FIFO is non-empty and out_stall is low,
//     the popped word appears on the registered outputs one edge later;
//   - there is no empty-FIFO bypass, so minimum push-to-output latency is
//     two cycles.
// -----------------------------------------------------------------------------
module fft_out_fifo
  import fft_out_fifo_pkg::*;
#(
  parameter int DEPTH     = FFT_FIFO_DEPTH,
  parameter int FRAME_LEN = FFT_FRAME_LEN
) (
  input  logic          clk,
  input  logic          reset,
  fft_out_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] FRAME_C    = CW'(FRAME_LEN);
  localparam logic [SW-1:0] LAST_IDX_C = SW'(FRAME_LEN - 1);

  // State
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic [SW-1:0] samp_cnt_q, samp_cnt_d;
  logic          out_push_q, out_push_d;
  logic          out_last_q, out_last_d;
  sample_t       out_real_q, out_real_d;
  sample_t       out_imag_q, out_imag_d;
  logic          in_stall_q, in_stall_d;
  logic          overflow_q, overflow_d;

  // Datapath
  logic  full;
  logic  empty;
  logic  do_push;
  logic  do_pop;
  word_t wr_word;
  word_t rd_word;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  // At full a push is dropped even if a pop frees a slot on the same edge.
  assign do_push = bus.in_push && !full;
  assign do_pop  = !bus.out_stall && !empty;
  assign wr_word = pack_word(bus.in_real, bus.in_imag);

  fft_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr_q),
    .wdata (wr_word),
    .raddr (rd_ptr_q),
    .rdata (rd_word)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    samp_cnt_d = samp_cnt_q;
    out_push_d = 1'b0;
    out_last_d = 1'b0;
    out_real_d = out_real_q;
    out_imag_d = out_imag_q;
    overflow_d = overflow_q;

    if (do_push) begin
      // Pointers are AW bits wide, so DEPTH being a power of two makes the
      // natural roll-over the modulo-DEPTH wrap.
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (bus.in_push && full) begin
      overflow_d = 1'b1;
    end

    if (do_pop) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      out_push_d = 1'b1;
      out_real_d = rd_word.re;
      out_imag_d = rd_word.im;
      out_last_d = (samp_cnt_q == LAST_IDX_C);
      samp_cnt_d = (samp_cnt_q == LAST_IDX_C) ? '0 : samp_cnt_q + SW'(1);
    end

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Looks at next-state occupancy so the flag lines up with count_F.
    in_stall_d = ((DEPTH_C - count_d) < FRAME_C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      samp_cnt_q <= '0;
      out_push_q <= 1'b0;
      out_last_q <= 1'b0;
      out_real_q <= '0;
      out_imag_q <= '0;
      in_stall_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      samp_cnt_q <= samp_cnt_d;
      out_push_q <= out_push_d;
      out_last_q <= out_last_d;
      out_real_q <= out_real_d;
      out_imag_q <= out_imag_d;
      in_stall_q <= in_stall_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.in_stall_F = in_stall_q;
  assign bus.out_push_F = out_push_q;
  assign bus.out_last_F = out_last_q;
  assign bus.out_real_F = out_real_q;
  assign bus.out_imag_F = out_imag_q;
  assign bus.overflow_F = overflow_q;
  assign bus.count_F    = count_q;

endmodule

// File: tb/tb_fft_out_fifo.sv
// -----------------------------------------------------------------------------
// tb_fft_out_fifo
// Directed self-checking bench for fft_out_fifo (DEPTH=32, FRAME_LEN=16).
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point; every popped sample is logged and queued so
// that order, data and frame markers can be checked after each scenario.
// -----------------------------------------------------------------------------
module tb_fft_out_fifo;
  import fft_out_fifo_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  fft_out_fifo_if #(.DEPTH(32)) bus ();

  fft_out_fifo #(
    .DEPTH     (32),
    .FRAME_LEN (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests      = 0;
  int fails      = 0;
  int stray_last = 0;

  // Popped samples, packed as {real, imag, last}.
  logic [32:0] got_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, take the edge, then sample outputs.
  task automatic step(input logic push, input int re, input int im, input logic stall);
    bus.in_push   = push;
    bus.in_real   = 16'(re);
    bus.in_imag   = 16'(im);
    bus.out_stall = stall;
    @(posedge clk);
    #1;
    if (bus.out_last_F === 1'b1 && bus.out_push_F !== 1'b1) stray_last++;
    if (bus.out_push_F === 1'b1) begin
      got_q.push_back({bus.out_real_F, bus.out_imag_F, bus.out_last_F});
      $display("[TB] pop real=%0d imag=%0d last=%0b",
               $signed(bus.out_real_F), $signed(bus.out_imag_F), bus.out_last_F);
    end
  endtask

  // Popped stream must be base+k / (+-)k, with last on every 16th sample.
  task automatic check_got(input string tag, input int n, input int base, input bit neg);
    chk({tag, "_npops"}, 64'(got_q.size()), 64'(n));
    for (int k = 0; k < n && k < got_q.size(); k++) begin
      logic [15:0] ei;
      logic [32:0] ew;
      ei = neg ? 16'(-k) : 16'(k);
      ew = {16'(base + k), ei, (k % 16 == 15)};
      chk($sformatf("%s_pop%0d", tag, k), 64'(got_q[k]), 64'(ew));
    end
  endtask

  // Raise reset between edges and check that outputs clear without a clock.
  task automatic do_reset(input string tag);
    bus.in_push   = 1'b0;
    bus.in_real   = '0;
    bus.in_imag   = '0;
    bus.out_stall = 1'b0;
    reset = 1'b1;
    #1;
    chk({tag, "_out_push"}, 64'(bus.out_push_F), 64'(0));
    chk({tag, "_out_last"}, 64'(bus.out_last_F), 64'(0));
    chk({tag, "_out_real"}, 64'(bus.out_real_F), 64'(0));
    chk({tag, "_out_imag"}, 64'(bus.out_imag_F), 64'(0));
    chk({tag, "_count"},    64'(bus.count_F),    64'(0));
    chk({tag, "_in_stall"}, 64'(bus.in_stall_F), 64'(0));
    chk({tag, "_overflow"}, 64'(bus.overflow_F), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("[TB] reset %s done", tag);
  endtask

  initial begin
    bus.in_push   = 1'b0;
    bus.in_real   = '0;
    bus.in_imag   = '0;
    bus.out_stall = 1'b0;
    #2;
    do_reset("rst0");

    // ---- One frame, no back-pressure: 2-cycle latency, in order ----------
    got_q.delete();
    step(1'b1, 0, 0, 1'b0);
    chk("s1_nopop_n1", 64'(bus.out_push_F), 64'(0));
    chk("s1_count_n1", 64'(bus.count_F), 64'(1));
    step(1'b1, 1, -1, 1'b0);
    chk("s1_pop_n2", 64'(bus.out_push_F), 64'(1));
    chk("s1_real_n2", 64'(bus.out_real_F), 64'(0));
    chk("s1_count_n2", 64'(bus.count_F), 64'(1));
    for (int k = 2; k < 16; k++) step(1'b1, k, -k, 1'b0);
    repeat (4) step(1'b0, 0, 0, 1'b0);
    check_got("s1", 16, 0, 1'b1);
    chk("s1_count_end", 64'(bus.count_F), 64'(0));

    // ---- Fill to 32 under stall, watch in_stall, then drain -------------
    got_q.delete();
    for (int k = 0; k < 32; k++) begin
      step(1'b1, 100 + k, k, 1'b1);
      chk($sformatf("s2_in_stall%0d", k), 64'(bus.in_stall_F), 64'(k + 1 >= 17));
    end
    chk("s2_count_full", 64'(bus.count_F), 64'(32));
    chk("s2_overflow", 64'(bus.overflow_F), 64'(0));
    chk("s2_nopop_stalled", 64'(got_q.size()), 64'(0));
    repeat (36) step(1'b0, 0, 0, 1'b0);
    check_got("s2", 32, 100, 1'b0);
    chk("s2_count_end", 64'(bus.count_F), 64'(0));
    chk("s2_in_stall_end", 64'(bus.in_stall_F), 64'(0));

    // ---- 33 pushes under stall: last one dropped, overflow sticky -------
    got_q.delete();
    for (int k = 0; k < 33; k++) begin
      step(1'b1, 200 + k, k, 1'b1);
      if (k == 31) chk("s3_overflow_at32", 64'(bus.overflow_F), 64'(0));
    end
    chk("s3_overflow_at33", 64'(bus.overflow_F), 64'(1));
    chk("s3_count", 64'(bus.count_F), 64'(32));
    repeat (36) step(1'b0, 0, 0, 1'b0);
    check_got("s3", 32, 200, 1'b0);
    chk("s3_overflow_sticky", 64'(bus.overflow_F), 64'(1));

    // ---- 10 entries, 20 cycles of push+pop; pointers wrap past 31 -------
    got_q.delete();
    for (int k = 0; k < 10; k++) step(1'b1, 300 + k, k, 1'b1);
    chk("s4_count_fill", 64'(bus.count_F), 64'(10));
    for (int k = 10; k < 30; k++) begin
      step(1'b1, 300 + k, k, 1'b0);
      chk($sformatf("s4_count%0d", k), 64'(bus.count_F), 64'(10));
    end
    repeat (14) step(1'b0, 0, 0, 1'b0);
    check_got("s4", 30, 300, 1'b0);
    chk("s4_overflow_sticky", 64'(bus.overflow_F), 64'(1));

    do_reset("rst_a");

    // ---- Toggle out_stall every cycle during a frame --------------------
    // Stall is low on even steps; pops land on even steps 2..32.
    got_q.delete();
    for (int k = 0; k < 33; k++) begin
      step(k < 16, 400 + k, k, 1'(k % 2));
      chk($sformatf("s5_push_step%0d", k), 64'(bus.out_push_F),
          64'((k % 2 == 0) && (k >= 2)));
    end
    check_got("s5", 16, 400, 1'b0);

    // ---- Reset after 7 samples, next frame restarts at sample 0 ---------
    got_q.delete();
    for (int k = 0; k < 7; k++) step(1'b1, 500 + k, k, 1'b0);
    do_reset("rst_b");
    got_q.delete();
    for (int k = 0; k < 16; k++) step(1'b1, 600 + k, k, 1'b0);
    repeat (4) step(1'b0, 0, 0, 1'b0);
    check_got("s6", 16, 600, 1'b0);

    chk("no_stray_last", 64'(stray_last), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
